// File: rtl/rf_pkg.sv
// Shared definitions for the register file and its operation sequencer:
// common widths, opcode values and the sequencer state encoding.
package rf_pkg;

  localparam int RF_DW = 16;
  localparam int RF_AW = 3;

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rf_addsub.sv
// Combinational DW-bit adder/subtractor. The carry or borrow out is dropped,
// so results wrap modulo 2**DW.
module rf_addsub #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] y
);

  // select add or subtract; opcode LSB distinguishes SUB from ADD
  always_comb begin
    if (sub) begin
      y = a - b;
    end else begin
      y = a + b;
    end
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Register-file operation sequencer: runs one MOVI/MOV/ADD/SUB per start
// pulse by reading sources through the regfile's combinational read port,
// then issuing a single write and a one-cycle done pulse.
module rf_op_sequencer
  import rf_pkg::*;
#(
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW,
  parameter int IMMW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      opcode,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rn,
  input  logic [AW-1:0]   rm,
  input  logic [IMMW-1:0] imm,
  input  logic [DW-1:0]   rf_data_out,
  output logic [AW-1:0]   rf_readnum,
  output logic [AW-1:0]   rf_writenum,
  output logic            rf_write,
  output logic [DW-1:0]   rf_data_in,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   result
);

  state_t          state_r;
  state_t          next_state_s;
  logic [1:0]      op_r;
  logic [AW-1:0]   rd_r;
  logic [AW-1:0]   rn_r;
  logic [AW-1:0]   rm_r;
  logic [DW-1:0]   a_r;
  logic [DW-1:0]   r_r;
  logic [DW-1:0]   result_r;
  logic [DW-1:0]   imm_sx_s;
  logic [DW-1:0]   addsub_s;

  assign imm_sx_s = {{(DW-IMMW){imm[IMMW-1]}}, imm};

  rf_addsub #(.DW(DW)) u_addsub (
    .a   (a_r),
    .b   (rf_data_out),
    .sub (op_r[0]),
    .y   (addsub_s)
  );

  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state decode; start is only looked at in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MOVI) begin
            next_state_s = S_WR;
          end else begin
            next_state_s = S_RD_A;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RD_A: begin
        if (op_r == OP_MOV) begin
          next_state_s = S_WR;
        end else begin
          next_state_s = S_RD_B;
        end
      end
      S_RD_B:  next_state_s = S_WR;
      S_WR:    next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // operand capture, result computation and completed-result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 2'b00;
      rd_r     <= {AW{1'b0}};
      rn_r     <= {AW{1'b0}};
      rm_r     <= {AW{1'b0}};
      a_r      <= {DW{1'b0}};
      r_r      <= {DW{1'b0}};
      result_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r <= opcode;
            rd_r <= rd;
            rn_r <= rn;
            rm_r <= rm;
            if (opcode == OP_MOVI) begin
              r_r <= imm_sx_s;
            end
          end
        end
        S_RD_A: begin
          if (op_r == OP_MOV) begin
            r_r <= rf_data_out;
          end else begin
            a_r <= rf_data_out;
          end
        end
        S_RD_B:  r_r <= addsub_s;
        // result becomes visible together with done in the following cycle
        S_WR:    result_r <= r_r;
        default: ;
      endcase
    end
  end

  // output decode from state; read select is parked at 0 when not reading
  always_comb begin
    rf_readnum = {AW{1'b0}};
    rf_write   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_r)
      S_IDLE:  busy       = 1'b0;
      S_RD_A:  rf_readnum = rn_r;
      S_RD_B:  rf_readnum = rm_r;
      S_WR:    rf_write   = 1'b1;
      S_DONE:  done       = 1'b1;
      default: busy       = 1'b0;
    endcase
  end

  assign rf_writenum = rd_r;
  assign rf_data_in  = r_r;
  assign result      = result_r;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: a behavioural 8x16 regfile driven only by the
// sequencer, a scoreboard queue filled at issue time from a plain array model
// of the register contents, and a monitor process that checks every write
// and every done pulse against the queue head.
module tb_rf_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [7:0]  imm;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic [15:0] regs [0:7];
  logic [15:0] model_regs [0:7];

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    time         t0;
    int          lat;
    int          nwr;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  rf_op_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .rd          (rd),
    .rn          (rn),
    .rm          (rm),
    .imm         (imm),
    .rf_data_out (rf_data_out),
    .rf_readnum  (rf_readnum),
    .rf_writenum (rf_writenum),
    .rf_write    (rf_write),
    .rf_data_in  (rf_data_in),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural register file: synchronous write, combinational read
  always @(posedge clk) begin
    if (rf_write) regs[rf_writenum] <= rf_data_in;
  end
  assign rf_data_out = regs[rf_readnum];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // monitor: compare each write and each done against the scoreboard head
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rf_write) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=wn %0d data %h required=no write",
                     rf_writenum, rf_data_in);
          end else begin
            chk("writenum", {29'd0, rf_writenum}, {29'd0, exp_q[0].rd});
            chk("data_in", {16'd0, rf_data_in}, {16'd0, exp_q[0].val});
            exp_q[0].nwr = exp_q[0].nwr + 1;
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            e = exp_q.pop_front();
            chk("result", {16'd0, result}, {16'd0, e.val});
            chk("latency", int'(($time - e.t0) / 10), e.lat);
            chk("write_count", e.nwr, 1);
            chk("regfile", {16'd0, regs[e.rd]}, {16'd0, e.val});
            chk("busy_in_done", {31'd0, busy}, 32'd1);
          end
        end
      end
    end
  endtask

  // issue one operation at a negedge; returns at the negedge where the next
  // operation may be issued (the cycle after done)
  task automatic do_op(input logic [1:0] op, input logic [2:0] d, input logic [2:0] n,
                       input logic [2:0] m, input logic [7:0] im, input bit hold);
    exp_t e;
    int   cyc;
    bit   got;
    e.rd  = d;
    e.t0  = $time;
    e.nwr = 0;
    case (op)
      2'b00:   begin e.val = {{8{im[7]}}, im};                e.lat = 2; end
      2'b01:   begin e.val = model_regs[n];                   e.lat = 3; end
      2'b10:   begin e.val = model_regs[n] + model_regs[m];   e.lat = 4; end
      default: begin e.val = model_regs[n] - model_regs[m];   e.lat = 4; end
    endcase
    exp_q.push_back(e);
    model_regs[d] = e.val;
    opcode = op; rd = d; rn = n; rm = m; imm = im;
    start  = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1'b1;
      end else begin
        start  = hold;
        opcode = 2'($urandom);
        rd     = 3'($urandom);
        rn     = 3'($urandom);
        rm     = 3'($urandom);
        imm    = 8'($urandom);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (!got) exp_q.delete();
    start = hold;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) model_regs[i] = 16'h0000;
    rst_n = 1'b0;
    start = 1'b0;
    opcode = 2'b00; rd = 3'd0; rn = 3'd0; rm = 3'd0; imm = 8'h00;
    #1;
    chk("rst_write", {31'd0, rf_write}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_readnum", {29'd0, rf_readnum}, 32'd0);
    chk("rst_writenum", {29'd0, rf_writenum}, 32'd0);
    chk("rst_data_in", {16'd0, rf_data_in}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none

    // clear the regfile through the sequencer
    for (int i = 0; i < 8; i++) do_op(2'b00, 3'(i), 3'd0, 3'd0, 8'h00, 1'b0);

    // MOVI sign extension
    do_op(2'b00, 3'd3, 3'd0, 3'd0, 8'hFE, 1'b0);
    chk("movi_fe", {16'd0, regs[3]}, 32'h0000FFFE);

    // ADD 5 + 7
    do_op(2'b00, 3'd1, 3'd0, 3'd0, 8'd5, 1'b0);
    do_op(2'b00, 3'd2, 3'd0, 3'd0, 8'd7, 1'b0);
    do_op(2'b10, 3'd4, 3'd1, 3'd2, 8'd0, 1'b0);
    chk("add_5_7", {16'd0, regs[4]}, 32'd12);

    // SUB borrow wrap, then ADD overflow wrap
    do_op(2'b00, 3'd1, 3'd0, 3'd0, 8'd0, 1'b0);
    do_op(2'b00, 3'd2, 3'd0, 3'd0, 8'd1, 1'b0);
    do_op(2'b11, 3'd0, 3'd1, 3'd2, 8'd0, 1'b0);
    chk("sub_wrap", {16'd0, regs[0]}, 32'h0000FFFF);
    do_op(2'b00, 3'd1, 3'd0, 3'd0, 8'h40, 1'b0);
    repeat (9) do_op(2'b10, 3'd1, 3'd1, 3'd1, 8'd0, 1'b0);
    chk("build_8000", {16'd0, regs[1]}, 32'h00008000);
    do_op(2'b10, 3'd2, 3'd1, 3'd1, 8'd0, 1'b0);
    chk("add_wrap", {16'd0, regs[2]}, 32'd0);

    // self-move and aliased sources
    do_op(2'b00, 3'd5, 3'd0, 3'd0, 8'h23, 1'b0);
    do_op(2'b01, 3'd5, 3'd5, 3'd0, 8'd0, 1'b0);
    chk("mov_self", {16'd0, regs[5]}, 32'h00000023);
    do_op(2'b00, 3'd1, 3'd0, 3'd0, 8'd3, 1'b0);
    do_op(2'b10, 3'd1, 3'd1, 3'd1, 8'd0, 1'b0);
    chk("add_alias", {16'd0, regs[1]}, 32'd6);

    // start held high through a busy ADD
    do_op(2'b10, 3'd4, 3'd1, 3'd5, 8'd0, 1'b1);

    // reset during RD_B of an ADD
    opcode = 2'b10; rd = 3'd4; rn = 3'd1; rm = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_rd_b", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_write", {31'd0, rf_write}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_dest", {16'd0, regs[4]}, {16'd0, model_regs[4]});
    rst_n = 1'b1;
    do_op(2'b00, 3'd6, 3'd0, 3'd0, 8'h81, 1'b0);
    chk("movi_after_rst", {16'd0, regs[6]}, 32'h0000FF81);

    // randomized operations
    for (int k = 0; k < 150; k++) begin
      do_op(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            8'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) chk("final_reg", {16'd0, regs[i]}, {16'd0, model_regs[i]});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
